// File: rtl/uart_tx_engine.sv
// rtl/uart_tx_engine.sv - UART transmit engine: start, LSB-first data, optional parity, stop.
// Optional parity (pen/ohel inputs) is enabled by defining UART_TX_PARITY_EN.
module uart_tx_engine #(
  parameter int DATA_BITS = 8,
  parameter int BAUD_DIV  = 10416
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [DATA_BITS-1:0] din,
`ifdef UART_TX_PARITY_EN
  input  logic                 pen,
  input  logic                 ohel,
`endif
  output logic                 tx,
  output logic                 tx_rdy,
  output logic                 tx_done
);

  // Shift register is sized for the longest frame; unused top bits stay at 1.
  localparam int NMAX = DATA_BITS + 3;
  localparam int CW   = $clog2(BAUD_DIV);
  localparam int BW   = $clog2(NMAX);

  typedef enum logic {IDLE, SEND} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   baud_q, baud_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [BW-1:0]   last_q, last_d;
  logic [NMAX-1:0] sh_q, sh_d;
  logic            done_q, done_d;
  logic            par_en;
  logic            par_bit;

`ifdef UART_TX_PARITY_EN
  assign par_en  = pen;
  assign par_bit = (^din) ^ ohel;
`else
  assign par_en  = 1'b0;
  assign par_bit = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      last_q  <= '0;
      sh_q    <= '1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      last_q  <= last_d;
      sh_q    <= sh_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    last_d  = last_q;
    sh_d    = sh_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          state_d = SEND;
          baud_d  = '0;
          bit_d   = '0;
          sh_d    = {1'b1, (par_en ? par_bit : 1'b1), din, 1'b0};
          // Index of the stop bit: frame length minus one, fixed per frame.
          last_d  = par_en ? BW'(DATA_BITS + 2) : BW'(DATA_BITS + 1);
        end
      end
      SEND: begin
        if (baud_q == CW'(BAUD_DIV - 1)) begin
          baud_d = '0;
          sh_d   = {1'b1, sh_q[NMAX-1:1]};
          if (bit_q == last_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx      = sh_q[0];
  assign tx_rdy  = (state_q == IDLE);
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// tb/tb_uart_tx_engine.sv - directed bench for uart_tx_engine (BAUD_DIV=4, DATA_BITS=8).
module tb_uart_tx_engine;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load = 1'b0;
  logic [7:0] din = 8'h00;
`ifdef UART_TX_PARITY_EN
  logic       pen = 1'b0;
  logic       ohel = 1'b0;
`endif
  logic       tx;
  logic       tx_rdy;
  logic       tx_done;

  int vectors = 0;
  int miscompares = 0;

  uart_tx_engine #(.DATA_BITS(8), .BAUD_DIV(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .din     (din),
`ifdef UART_TX_PARITY_EN
    .pen     (pen),
    .ohel    (ohel),
`endif
    .tx      (tx),
    .tx_rdy  (tx_rdy),
    .tx_done (tx_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_tx", tx, 1'b1);
      chk("idle_rdy", tx_rdy, 1'b1);
      chk("idle_done", tx_done, 1'b0);
    end
  endtask

  // Starts a frame at the next edge k, checks every cycle k+1.. and the done cycle.
  // busy_at: cycle whose following edge sees a stray load of 0xFF (0 = none).
  // abort_at: cycle whose following edge sees reset (0 = none).
  task automatic frame(input logic [7:0] d, input int nbits, input logic [10:0] eb,
                       input int busy_at, input int abort_at, input bit hold,
                       input logic [7:0] next_d);
    din  = d;
    load = 1'b1;
    @(posedge clk);
    #1;
    if (hold) din = next_d;
    else load = 1'b0;
    for (int c = 1; c <= nbits * 4; c++) begin
      @(negedge clk);
      chk("tx_bit", tx, eb[(c - 1) / 4]);
      chk("rdy_busy", tx_rdy, 1'b0);
      chk("done_busy", tx_done, 1'b0);
      if (busy_at > 0 && c == busy_at) begin
        load = 1'b1;
        din  = 8'hFF;
      end else if (busy_at > 0 && c == busy_at + 1) begin
        load = 1'b0;
        din  = d;
      end
      if (abort_at > 0 && c == abort_at) begin
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("abort_tx", tx, 1'b1);
        chk("abort_rdy", tx_rdy, 1'b1);
        chk("abort_done", tx_done, 1'b0);
        return;
      end
    end
    @(negedge clk);
    chk("end_done", tx_done, 1'b1);
    chk("end_rdy", tx_rdy, 1'b1);
    chk("end_tx", tx, 1'b1);
  endtask

  initial begin
    // Reset held three cycles.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx", tx, 1'b1);
    chk("rst_rdy", tx_rdy, 1'b1);
    chk("rst_done", tx_done, 1'b0);
    reset = 1'b0;
    idle_check(6);

    // Basic frame 0x55.
    frame(8'h55, 10, 11'b1_1_0101_0101_0, 0, 0, 1'b0, 8'h00);
    idle_check(3);

    // Stray load during frame is ignored.
    frame(8'hA3, 10, 11'b1_1_1010_0011_0, 10, 0, 1'b0, 8'h00);
    idle_check(3);

    // Reset mid-frame during data, then a clean 0x0F frame.
    frame(8'hC6, 10, 11'b1_1_1100_0110_0, 0, 17, 1'b0, 8'h00);
    idle_check(3);
    frame(8'h0F, 10, 11'b1_1_0000_1111_0, 0, 0, 1'b0, 8'h00);
    idle_check(2);

    // Back-to-back with load held high: second start bit right after tx_done.
    frame(8'h00, 10, 11'b1_1_0000_0000_0, 0, 0, 1'b1, 8'hFF);
    frame(8'hFF, 10, 11'b1_1_1111_1111_0, 0, 0, 1'b0, 8'h00);
    idle_check(3);

`ifdef UART_TX_PARITY_EN
    pen = 1'b1; ohel = 1'b0;
    frame(8'h07, 11, 11'b1_1_0000_0111_0, 0, 0, 1'b0, 8'h00);
    idle_check(2);
    pen = 1'b1; ohel = 1'b1;
    frame(8'h07, 11, 11'b1_0_0000_0111_0, 0, 0, 1'b0, 8'h00);
    idle_check(2);
    pen = 1'b0; ohel = 1'b0;
    frame(8'h07, 10, 11'b1_1_0000_0111_0, 0, 0, 1'b0, 8'h00);
    idle_check(2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
